// File: rtl/fetch_unit.sv
// Instruction-fetch stage: pipelined requests to a variable-latency instruction memory,
// in-order response buffer to decode, and branch/jump redirect with in-flight discard.
module fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            req_en_q;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] discard_q, discard_d;

  logic [XLEN-1:0] buf_instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] buf_pc_q    [FIFO_DEPTH];
  logic [XLEN-1:0] pcq_q       [FIFO_DEPTH];

  logic            issue, push, pop, head_vld, has_credit;
  logic [CntW:0]   inflight;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Buffered words and words still in flight share one credit pool so a push never overflows.
  assign inflight   = {1'b0, count_q} + {1'b0, outstanding_q};
  assign has_credit = inflight < (CntW + 1)'(FIFO_DEPTH);

  assign head_vld       = count_q != '0;
  assign imem_req       = req_en_q & ~redirect_valid & has_credit;
  assign imem_addr      = fetch_pc_q;
  assign instr_valid    = head_vld & ~redirect_valid;
  assign instr          = head_vld ? buf_instr_q[rd_ptr_q] : '0;
  assign instr_pc       = head_vld ? buf_pc_q[rd_ptr_q] : '0;
  assign instr_pc_plus4 = head_vld ? buf_pc_q[rd_ptr_q] + XLEN'(4) : '0;

  assign issue = imem_req & imem_gnt;
  assign push  = imem_rvalid & (discard_q == '0) & ~redirect_valid;
  assign pop   = instr_valid & instr_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CntW'(issue) - CntW'(imem_rvalid);
    pcq_wr_d      = issue ? pcq_wr_q + PtrW'(1) : pcq_wr_q;
    pcq_rd_d      = imem_rvalid ? pcq_rd_q + PtrW'(1) : pcq_rd_q;

    if (redirect_valid) begin
      // Every request still in flight after this cycle's response belongs to the old path.
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      discard_d  = outstanding_q - CntW'(imem_rvalid);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (imem_rvalid && discard_q != '0) discard_d = discard_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_VECTOR;
      req_en_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_en_q      <= 1'b1;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pcq_wr_q      <= pcq_wr_d;
      pcq_rd_q      <= pcq_rd_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Payload storage needs no reset: count/pointers qualify every read.
  always_ff @(posedge clk) begin
    if (issue) pcq_q[pcq_wr_q] <= fetch_pc_q;
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]    <= pcq_q[pcq_rd_q];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (push && !pop) |-> (count_q != CntW'(FIFO_DEPTH)));

  a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized memory/decode environment compared each cycle
// against a queue-based reference of fetched, in-flight and buffered instructions.
module tb_fetch_unit;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr, instr_pc, instr_pc_plus4;

  fetch_unit #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pc_plus4(instr_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
  } pop_t;

  req_t        mem_q[$];
  ent_t        fifo_q[$];
  pop_t        obs_pops[$];
  logic [31:0] issue_log[$];
  logic [31:0] fetch_pc;
  int          cyc;
  int          lat_min = 1, lat_max = 1, gnt_pct = 100;
  int          n_checks = 0, n_fail = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock cycle: drive environment, compare DUT outputs with the reference, advance it.
  task automatic step(input logic redir, input logic [31:0] tgt, input logic rdy);
    logic        rv, gnt, exp_req, exp_valid;
    logic [31:0] exp_instr, exp_pc, exp_pc4;
    int          due;
    req_t        r;
    @(negedge clk);
    rv  = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    gnt = ($urandom_range(99) < gnt_pct);
    redirect_valid = redir;
    redirect_pc    = tgt;
    instr_ready    = rdy;
    imem_gnt       = gnt;
    imem_rvalid    = rv;
    imem_rdata     = rv ? word_of(mem_q[0].addr) : $urandom;
    #1;
    exp_req   = !redir && (fifo_q.size() + mem_q.size() < Depth);
    exp_valid = (fifo_q.size() != 0) && !redir;
    exp_instr = (fifo_q.size() != 0) ? fifo_q[0].word : 32'h0;
    exp_pc    = (fifo_q.size() != 0) ? fifo_q[0].pc : 32'h0;
    exp_pc4   = (fifo_q.size() != 0) ? fifo_q[0].pc + 32'd4 : 32'h0;

    n_checks++;
    if (imem_req !== exp_req) begin
      n_fail++;
      $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
    end
    n_checks++;
    if (imem_addr !== fetch_pc) begin
      n_fail++;
      $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, fetch_pc);
    end
    n_checks++;
    if (instr_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, exp_valid);
    end
    n_checks++;
    if ({instr, instr_pc, instr_pc_plus4} !== {exp_instr, exp_pc, exp_pc4}) begin
      n_fail++;
      $display("FAIL head cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, instr, instr_pc,
               instr_pc_plus4, exp_instr, exp_pc, exp_pc4);
    end

    if (imem_req && gnt) issue_log.push_back(imem_addr);
    if (instr_valid && rdy) obs_pops.push_back('{pc: instr_pc, pc4: instr_pc_plus4});

    if (exp_valid && rdy) void'(fifo_q.pop_front());
    if (rv) begin
      r = mem_q.pop_front();
      if (!r.stale && !redir) fifo_q.push_back('{word: word_of(r.addr), pc: r.addr});
    end
    if (redir) begin
      fifo_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      fetch_pc = tgt & 32'hFFFF_FFFC;
    end
    if (exp_req && gnt) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (mem_q.size() > 0 && due <= mem_q[mem_q.size()-1].due) due = mem_q[mem_q.size()-1].due + 1;
      mem_q.push_back('{addr: fetch_pc, due: due, stale: 1'b0});
      fetch_pc = fetch_pc + 32'd4;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    redirect_valid = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, instr_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ctrl got req/valid=%b%b exp=00", imem_req, instr_valid);
    end
    n_checks++;
    if ({imem_addr, instr, instr_pc, instr_pc_plus4} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h/%h/%h exp all zero", imem_addr, instr, instr_pc,
               instr_pc_plus4);
    end
    mem_q.delete();
    fifo_q.delete();
    fetch_pc = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_before_first_edge got=%b exp=0", imem_req);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic clear_logs();
    obs_pops.delete();
    issue_log.delete();
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_stream();
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    apply_reset();
    clear_logs();
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (obs_pops.size() < 3) begin
      n_fail++;
      $display("FAIL stream_count got=%0d exp>=3", obs_pops.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_pops[i].pc !== 32'(4 * i) || obs_pops[i].pc4 !== 32'(4 * i + 4)) begin
          n_fail++;
          $display("FAIL stream_pc[%0d] got=%h/%h exp=%h/%h", i, obs_pops[i].pc,
                   obs_pops[i].pc4, 4 * i, 4 * i + 4);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    apply_reset();
    clear_logs();
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);
    n_checks++;
    if (issue_log.size() != 4) begin
      n_fail++;
      $display("FAIL bp_issues got=%0d exp=4", issue_log.size());
    end
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (obs_pops.size() < 4) begin
      n_fail++;
      $display("FAIL bp_pops got=%0d exp>=4", obs_pops.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_pops[i].pc !== 32'(4 * i)) begin
          n_fail++;
          $display("FAIL bp_pc[%0d] got=%h exp=%h", i, obs_pops[i].pc, 4 * i);
        end
      end
    end
    n_checks++;
    if (issue_log.size() < 5 || issue_log[4] !== 32'h10) begin
      n_fail++;
      $display("FAIL bp_resume got=%h exp=00000010",
               (issue_log.size() > 4) ? issue_log[4] : 32'hX);
    end
  endtask

  task automatic test_redirect_flush();
    lat_min = 3; lat_max = 3; gnt_pct = 100;
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h100, 1'b1);
    clear_logs();
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (obs_pops.size() == 0 || obs_pops[0].pc !== 32'h100) begin
      n_fail++;
      $display("FAIL flush_first got=%h exp=00000100",
               (obs_pops.size() > 0) ? obs_pops[0].pc : 32'hX);
    end
    foreach (obs_pops[i]) begin
      n_checks++;
      if (obs_pops[i].pc !== 32'h100 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL flush_seq[%0d] got=%h exp=%h", i, obs_pops[i].pc, 32'h100 + 4 * i);
      end
    end
  endtask

  task automatic test_redirect_coincident();
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    apply_reset();
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    clear_logs();
    // Head word 0 is poppable and word 4 returns in this very cycle.
    step(1'b1, 32'h203, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (issue_log.size() == 0 || issue_log[0] !== 32'h200) begin
      n_fail++;
      $display("FAIL redir_addr got=%h exp=00000200",
               (issue_log.size() > 0) ? issue_log[0] : 32'hX);
    end
    n_checks++;
    if (obs_pops.size() == 0 || obs_pops[0].pc !== 32'h200) begin
      n_fail++;
      $display("FAIL redir_first_pop got=%h exp=00000200",
               (obs_pops.size() > 0) ? obs_pops[0].pc : 32'hX);
    end
  endtask

  task automatic test_wrap();
    lat_min = 1; lat_max = 2; gnt_pct = 100;
    apply_reset();
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    clear_logs();
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (obs_pops.size() < 3) begin
      n_fail++;
      $display("FAIL wrap_count got=%0d exp>=3", obs_pops.size());
    end else begin
      n_checks++;
      if (obs_pops[0].pc !== 32'hFFFF_FFF8 || obs_pops[1].pc !== 32'hFFFF_FFFC ||
          obs_pops[2].pc !== 32'h0) begin
        n_fail++;
        $display("FAIL wrap_pcs got=%h,%h,%h exp=fffffff8,fffffffc,00000000",
                 obs_pops[0].pc, obs_pops[1].pc, obs_pops[2].pc);
      end
      n_checks++;
      if (obs_pops[1].pc4 !== 32'h0) begin
        n_fail++;
        $display("FAIL wrap_plus4 got=%h exp=00000000", obs_pops[1].pc4);
      end
    end
  endtask

  task automatic test_reset_midstream();
    lat_min = 3; lat_max = 3; gnt_pct = 100;
    apply_reset();
    step(1'b1, 32'h400, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    apply_reset();
    clear_logs();
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (obs_pops.size() == 0 || obs_pops[0].pc !== 32'h0) begin
      n_fail++;
      $display("FAIL restart_pc got=%h exp=00000000",
               (obs_pops.size() > 0) ? obs_pops[0].pc : 32'hX);
    end
  endtask

  task automatic test_random();
    logic        redir;
    logic [31:0] tgt;
    lat_min = 1; lat_max = 4; gnt_pct = 70;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      redir = ($urandom_range(99) < 4);
      tgt   = $urandom;
      step(redir, tgt, $urandom_range(99) < 70);
    end
  endtask

  initial begin
    cyc = 0;
    fetch_pc = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_coincident();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
